// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory request arbiter.
package mem_arb_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        STARTUP,
        IDLE,
        WAIT,
        RECOVER,
        DRAIN
    } arb_state_t;

    localparam logic [1:0] MC_ST_ERROR = 2'd0;
    localparam logic [1:0] MC_ST_BUSY  = 2'd1;
    localparam logic [1:0] MC_ST_DONE  = 2'd2;

    // One request as presented on the MemoryController port.
    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              write;
        logic              virt;
        logic              exec;
    } mc_req_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first valid requester scanning upward from ptr+1 with wrap.
module rr_pick #(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IDX_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [IDX_W-1:0]   idx_c,
    output logic               any_c
);

    // Walk offsets from farthest to nearest so the nearest valid candidate wins.
    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        any_c   = 1'b0;
        for (int off = int'(NUM_REQ); off > 0; off--) begin
            int cand;
            cand = (int'(ptr) + off) % int'(NUM_REQ);
            if (valid[IDX_W'(cand)]) begin
                grant_c                 = '0;
                grant_c[IDX_W'(cand)]   = 1'b1;
                idx_c                   = IDX_W'(cand);
                any_c                   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_request_arbiter.sv
// Round-robin sequencer sharing the single MemoryController request port,
// with startup drain, post-error recovery and completion watchdog.
module mem_request_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned STARTUP_CYCLES = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        reqValid,
    input  logic [NUM_REQ*DATA_W-1:0] reqAddr,
    input  logic [NUM_REQ*DATA_W-1:0] reqWData,
    input  logic [NUM_REQ-1:0]        reqWrite,
    input  logic [NUM_REQ-1:0]        reqVirtual,
    input  logic [NUM_REQ-1:0]        reqExec,
    output logic [NUM_REQ-1:0]        reqAck,
    output logic [NUM_REQ-1:0]        rspValid,
    output logic [DATA_W-1:0]         rspData,
    output logic                      rspError,
    output logic [DATA_W-1:0]         mcRamAddress,
    output logic [DATA_W-1:0]         mcRamIn,
    output logic                      mcRequest,
    output logic                      mcWriteEnable,
    output logic                      mcAddrVirtual,
    output logic                      mcExecMode,
    input  logic [DATA_W-1:0]         mcRamOut,
    input  logic [1:0]                mcStatus
);

    localparam int unsigned IDX_W   = $clog2(NUM_REQ);
    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > STARTUP_CYCLES) ? TIMEOUT_CYCLES
                                                                        : STARTUP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    arb_state_t           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
    logic                 rsp_err_q, rsp_err_d;
    mc_req_t              mc_q, mc_d;
    logic                 mc_req_q, mc_req_d;

    logic [NUM_REQ-1:0]   pick_gnt_c;
    logic [IDX_W-1:0]     pick_idx_c;
    logic                 pick_any_c;
    mc_req_t              req_arr [NUM_REQ];

    // Unpack the flat per-requester buses into one payload per slot.
    for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_slot
        assign req_arr[i] = '{
            addr:  reqAddr[DATA_W*i +: DATA_W],
            wdata: reqWData[DATA_W*i +: DATA_W],
            write: reqWrite[i],
            virt:  reqVirtual[i],
            exec:  reqExec[i]
        };
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .valid   (reqValid),
        .ptr     (ptr_q),
        .grant_c (pick_gnt_c),
        .idx_c   (pick_idx_c),
        .any_c   (pick_any_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= STARTUP;
            cnt_q       <= '0;
            ptr_q       <= IDX_W'(NUM_REQ - 1);
            gnt_q       <= '0;
            ack_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            mc_q        <= '0;
            mc_req_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            mc_q        <= mc_d;
            mc_req_q    <= mc_req_d;
        end
    end

    // Next state and next registered outputs; pulses default low, payloads hold.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        ack_d       = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        mc_d        = mc_q;
        mc_req_d    = 1'b0;

        case (state_q)
            STARTUP: begin
                if (cnt_q == CNT_W'(STARTUP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            IDLE: begin
                if (pick_any_c) begin
                    gnt_d    = pick_gnt_c;
                    ptr_d    = pick_idx_c;
                    ack_d    = pick_gnt_c;
                    mc_d     = req_arr[pick_idx_c];
                    mc_req_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A real status in the expiry cycle takes precedence over the watchdog.
                if (mcStatus == MC_ST_DONE) begin
                    rsp_valid_d = gnt_q;
                    rsp_data_d  = mc_q.write ? '0 : mcRamOut;
                    rsp_err_d   = 1'b0;
                    state_d     = IDLE;
                end else if (mcStatus == MC_ST_ERROR) begin
                    rsp_valid_d = gnt_q;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = RECOVER;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_valid_d = gnt_q;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = DRAIN;
                end
            end
            RECOVER: begin
                state_d = IDLE;
            end
            DRAIN: begin
                // The late completion is swallowed; the requester already saw an error.
                if (mcStatus == MC_ST_DONE || mcStatus == MC_ST_ERROR) begin
                    state_d = RECOVER;
                end
            end
            default: begin
                state_d = STARTUP;
                cnt_d   = '0;
            end
        endcase
    end

    assign reqAck        = ack_q;
    assign rspValid      = rsp_valid_q;
    assign rspData       = rsp_data_q;
    assign rspError      = rsp_err_q;
    assign mcRamAddress  = mc_q.addr;
    assign mcRamIn       = mc_q.wdata;
    assign mcRequest     = mc_req_q;
    assign mcWriteEnable = mc_q.write;
    assign mcAddrVirtual = mc_q.virt;
    assign mcExecMode    = mc_q.exec;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Randomized bench: requesters and an MC model drive the arbiter; a
// transaction-level timing model predicts every grant and response.
module tb_mem_request_arbiter;
    import mem_arb_pkg::*;

    localparam int N  = 3;
    localparam int TO = 64;
    localparam int SU = 8;
    localparam int NEVER = 32'h3fff_ffff;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      reqValid, reqWrite, reqVirtual, reqExec;
    logic [N*32-1:0]   reqAddr, reqWData;
    logic [N-1:0]      reqAck, rspValid;
    logic [31:0]       rspData, mcRamAddress, mcRamIn, mcRamOut;
    logic              rspError, mcRequest, mcWriteEnable, mcAddrVirtual, mcExecMode;
    logic [1:0]        mcStatus;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mem_request_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO),
        .STARTUP_CYCLES (SU)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .reqValid      (reqValid),
        .reqAddr       (reqAddr),
        .reqWData      (reqWData),
        .reqWrite      (reqWrite),
        .reqVirtual    (reqVirtual),
        .reqExec       (reqExec),
        .reqAck        (reqAck),
        .rspValid      (rspValid),
        .rspData       (rspData),
        .rspError      (rspError),
        .mcRamAddress  (mcRamAddress),
        .mcRamIn       (mcRamIn),
        .mcRequest     (mcRequest),
        .mcWriteEnable (mcWriteEnable),
        .mcAddrVirtual (mcAddrVirtual),
        .mcExecMode    (mcExecMode),
        .mcRamOut      (mcRamOut),
        .mcStatus      (mcStatus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int          last_g, free_at, hold_off;
    bit          exp_req_pend, exp_rsp_pend, exp_rsp_err, exp_rsp_chk;
    int          exp_req_cyc, exp_g, exp_rsp_cyc, exp_rsp_g;
    logic [31:0] exp_addr, exp_wdata, exp_rsp_data;
    logic        exp_w, exp_v, exp_x;
    bit          first_txn;

    // MC model state.
    bit          mc_pend;
    int          mc_st_cyc;
    logic [1:0]  mc_st_val;
    logic [31:0] mc_rdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        last_g       = N - 1;
        free_at      = cyc + SU;
        exp_req_pend = 1'b0;
        exp_rsp_pend = 1'b0;
        if (mc_pend && (mc_st_cyc <= cyc || mc_st_cyc >= free_at)) mc_pend = 1'b0;
    endtask

    task automatic step();
        logic [N-1:0] ev;
        bit           er;
        int           lat, sel;
        @(posedge clk);
        #1;
        // Responses.
        ev = '0;
        if (exp_rsp_pend && cyc == exp_rsp_cyc) ev = N'(1) << exp_rsp_g;
        check_eq("rspValid", 32'(rspValid), 32'(ev));
        if (ev != '0) begin
            check_eq("rspError", 32'(rspError), 32'(exp_rsp_err));
            if (exp_rsp_chk) check_eq("rspData", rspData, exp_rsp_data);
            exp_rsp_pend = 1'b0;
        end
        // Grants.
        er = exp_req_pend && cyc == exp_req_cyc;
        check_eq("mcRequest", 32'(mcRequest), 32'(er));
        check_eq("reqAck", 32'(reqAck), er ? 32'(N'(1) << exp_g) : 32'd0);
        if (er) begin
            check_eq("mcRamAddress", mcRamAddress, exp_addr);
            check_eq("mcRamIn", mcRamIn, exp_wdata);
            check_eq("mcWriteEnable", 32'(mcWriteEnable), 32'(exp_w));
            check_eq("mcAddrVirtual", 32'(mcAddrVirtual), 32'(exp_v));
            check_eq("mcExecMode", 32'(mcExecMode), 32'(exp_x));
            exp_req_pend = 1'b0;
            reqValid[exp_g] = 1'b0;
        end
        // MC model reacts to an issued request and the model derives the response.
        if (mcRequest) begin
            sel      = $urandom_range(0, 19);
            mc_rdata = $urandom;
            if (first_txn) begin
                lat = 3; mc_st_val = MC_ST_DONE; mc_rdata = 32'hDEADBEEF; first_txn = 1'b0;
            end else if (sel <= 10) begin
                lat = $urandom_range(1, 6); mc_st_val = MC_ST_DONE;
            end else if (sel <= 13) begin
                lat = $urandom_range(1, 6); mc_st_val = MC_ST_ERROR;
            end else if (sel <= 15) begin
                lat = TO - 1; mc_st_val = MC_ST_DONE;
            end else begin
                lat = $urandom_range(TO, TO + 26);
                mc_st_val = ($urandom_range(0, 1) == 0) ? MC_ST_DONE : MC_ST_ERROR;
            end
            mc_pend      = 1'b1;
            mc_st_cyc    = cyc + lat;
            exp_rsp_pend = 1'b1;
            exp_rsp_g    = last_g;
            if (lat <= TO - 1) begin
                exp_rsp_cyc  = cyc + lat + 1;
                exp_rsp_err  = (mc_st_val == MC_ST_ERROR);
                exp_rsp_chk  = 1'b1;
                exp_rsp_data = (mc_st_val == MC_ST_DONE && !exp_w) ? mc_rdata : 32'd0;
                free_at      = exp_rsp_err ? cyc + lat + 2 : cyc + lat + 1;
            end else begin
                exp_rsp_cyc = cyc + TO;
                exp_rsp_err = 1'b1;
                exp_rsp_chk = 1'b0;
                free_at     = cyc + lat + 2;
            end
        end
        if (mc_pend && cyc == mc_st_cyc) begin
            mcStatus = mc_st_val;
            mcRamOut = mc_rdata;
            mc_pend  = 1'b0;
        end else begin
            mcStatus = MC_ST_BUSY;
            mcRamOut = $urandom;
        end
        // Requesters: hold until acked, then maybe raise a fresh request later.
        if (cyc == hold_off && first_txn) begin
            reqValid[0]      = 1'b1;
            reqAddr[31:0]    = 32'h100;
            reqWData[31:0]   = 32'h0;
            reqWrite[0]      = 1'b0;
            reqVirtual[0]    = 1'b0;
            reqExec[0]       = 1'b0;
        end else if (cyc > hold_off) begin
            for (int i = 0; i < N; i++) begin
                if (!reqValid[i] && $urandom_range(0, 3) == 0) begin
                    reqValid[i]        = 1'b1;
                    reqAddr[i*32 +: 32]  = ($urandom_range(0, 3) == 0) ? 32'h2000 : $urandom;
                    reqWData[i*32 +: 32] = $urandom;
                    reqWrite[i]        = 1'($urandom_range(0, 1));
                    reqVirtual[i]      = 1'($urandom_range(0, 1));
                    reqExec[i]         = 1'($urandom_range(0, 1));
                end
            end
        end
        // Arbitration decision for this cycle, visible on the next one.
        if (cyc >= free_at && reqValid != '0) begin
            for (int off = 1; off <= N; off++) begin
                int c;
                c = (last_g + off) % N;
                if (reqValid[c] && !exp_req_pend) begin
                    exp_g        = c;
                    exp_req_pend = 1'b1;
                end
            end
            last_g      = exp_g;
            exp_req_cyc = cyc + 1;
            exp_addr    = reqAddr[exp_g*32 +: 32];
            exp_wdata   = reqWData[exp_g*32 +: 32];
            exp_w       = reqWrite[exp_g];
            exp_v       = reqVirtual[exp_g];
            exp_x       = reqExec[exp_g];
            free_at     = NEVER;
        end
    endtask

    initial begin
        bit found;
        reset      = 1'b0;
        reqValid   = '0;
        reqAddr    = '0;
        reqWData   = '0;
        reqWrite   = '0;
        reqVirtual = '0;
        reqExec    = '0;
        mcStatus   = MC_ST_BUSY;
        mcRamOut   = '0;
        mc_pend    = 1'b0;
        first_txn  = 1'b1;
        #2;
        check_eq("reset_mcRequest", 32'(mcRequest), 32'd0);
        check_eq("reset_reqAck", 32'(reqAck), 32'd0);
        check_eq("reset_rspValid", 32'(rspValid), 32'd0);
        check_eq("reset_mcRamAddress", mcRamAddress, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        hold_off = cyc + 2;
        repeat (1500) step();

        // Reset in the middle of an outstanding transaction.
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            step();
            if (mc_pend && mc_st_cyc > cyc + 2 && !exp_req_pend) found = 1'b1;
        end
        check_eq("reach_mid_wait", 32'(found), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("arst_reqAck", 32'(reqAck), 32'd0);
        check_eq("arst_rspValid", 32'(rspValid), 32'd0);
        check_eq("arst_rspData", rspData, 32'd0);
        check_eq("arst_rspError", 32'(rspError), 32'd0);
        check_eq("arst_mcRamAddress", mcRamAddress, 32'd0);
        check_eq("arst_mcRamIn", mcRamIn, 32'd0);
        check_eq("arst_mcRequest", 32'(mcRequest), 32'd0);
        check_eq("arst_mcFlags", {29'd0, mcWriteEnable, mcAddrVirtual, mcExecMode}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        hold_off = cyc;
        repeat (1500) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_request_arbiter.md
Name: mem_request_arbiter

Overview:
Round-robin arbiter and sequencer in front of MemoryController, sharing its single mc* request port between NUM_REQ requesters (e.g. instruction fetch, data load/store). Issues exactly one single-cycle mcRequest per transaction and tracks mcStatus until done or error. Returns read data or error to the winning requester. Adds a startup drain, a post-error recovery cycle and a completion watchdog.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
TIMEOUT_CYCLES, 64, max WAIT cycles before watchdog error (≥16)
STARTUP_CYCLES, 8, idle cycles after reset before first grant (≥8, covers longest MC sequence)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
reqValid  in  NUM_REQ  per-requester request, held until reqAck
reqAddr  in  NUM_REQ*32  per-requester address, slot i = bits [32i+31:32i]
reqWData  in  NUM_REQ*32  per-requester write data
reqWrite  in  NUM_REQ  1=write
reqVirtual  in  NUM_REQ  1=virtual address
reqExec  in  NUM_REQ  exec-mode flag
reqAck  out  NUM_REQ  one-hot, 1-cycle pulse: request accepted
rspValid  out  NUM_REQ  one-hot, 1-cycle pulse: transaction finished
rspData  out  32  read data, valid with rspValid
rspError  out  1  1=MC error or watchdog, valid with rspValid
mcRamAddress  out  32  to MC
mcRamIn  out  32  to MC
mcRequest  out  1  to MC, single-cycle pulse
mcWriteEnable  out  1  to MC
mcAddrVirtual  out  1  to MC
mcExecMode  out  1  to MC
mcRamOut  in  32  from MC
mcStatus  in  2  from MC: 0=error, 1=busy/idle, 2=done (1-cycle)

Behaviour:
- All outputs registered. Reset (reset=0, async): all outputs 0, rrPtr=NUM_REQ-1 (requester 0 wins first), state=STARTUP, counter=0.
- STARTUP: mcRequest=0; count STARTUP_CYCLES, then IDLE. MC has no reset; this drains any in-flight MC sequence. Mid-operation reset always re-enters STARTUP; any lost transaction gets no rspValid.
- IDLE: if any reqValid, grant g = first set bit scanning from rrPtr+1 upward with wrap. Same edge: latch reqAddr/WData/Write/Virtual/Exec[g] onto mc* outputs, mcRequest<=1, reqAck[g]<=1, rrPtr<=g, timer<=0, state<=WAIT. No request: hold outputs, mcRequest=0.
- WAIT: mcRequest<=0 and reqAck<=0 on first cycle (both exactly 1-cycle pulses). timer increments each cycle.
  - mcStatus==2: rspValid[g]<=1, rspData<=mcRamOut (reads; writes return 0), rspError<=0, state<=IDLE.
  - mcStatus==0: rspValid[g]<=1, rspError<=1, rspData<=0, state<=RECOVER.
  - timer==TIMEOUT_CYCLES-1 with neither: rspValid[g]<=1, rspError<=1, state<=DRAIN.
  - Same-cycle status 2/0 and timer expiry: status wins.
- RECOVER: 1 cycle, no request (MC spends a cycle in its error state and would drop a request), then IDLE.
- DRAIN: no response emitted; wait for mcStatus 2 or 0 (discarded), then RECOVER. No timeout in DRAIN.
- rspValid pulses one cycle, cleared next cycle. Earliest back-to-back grant: the cycle after rspValid (IDLE), so mcRequest arrives when MC is in Ready.
- Throughput: one transaction in flight; request-to-response latency = MC latency + 1.
- reqValid dropped before reqAck: ignored, no side effect. Inputs of non-granted requesters ignored.
- Simultaneous requests: strict round-robin; a requester holding reqValid is granted within NUM_REQ transactions.

Decomposition:
- Package mem_arb_pkg: state enum (STARTUP, IDLE, WAIT, RECOVER, DRAIN); mcStatus constants MC_ST_ERROR=2'd0, MC_ST_BUSY=2'd1, MC_ST_DONE=2'd2.
- Sub-module rr_pick (combinational): inputs valid vector and rrPtr; outputs one-hot grant and index. Parameterised on NUM_REQ.

Test Plan:
- Reset, then reqValid[0] read addr 0x100 at cycle 2 -> no mcRequest before STARTUP_CYCLES elapse; then one mcRequest pulse with mcRamAddress=0x100; MC returns status 2 with mcRamOut=0xDEADBEEF -> rspValid[0] for 1 cycle, rspData=0xDEADBEEF, rspError=0.
- reqValid[0] and [1] both held for 4 transactions -> grant order 0,1,0,1; each mcRequest exactly 1 cycle; each next mcRequest ≥1 cycle after preceding rspValid.
- Virtual exec request, MC returns status 0 -> rspValid with rspError=1; no mcRequest in the following RECOVER cycle even with reqValid[1] high; grant to 1 on the cycle after.
- MC model never completes (status stuck 1) -> rspError pulse at TIMEOUT_CYCLES (64); status 2 at cycle 80 absorbed without rspValid; next request then serviced.
- Write 0x12345678 to 0x2000 by requester 1 -> mcWriteEnable=1, mcRamIn=0x12345678; rspValid[1] with rspData=0.
- Assert reset=0 mid-WAIT -> all outputs 0 asynchronously; after release, STARTUP re-entered; no stale rspValid.
